// File: rtl/ms_operand_loader.sv
// rtl/ms_operand_loader.sv - collects x/y/z operand bytes, issues them to the
// multiply-subtract unit and holds its result until the consumer takes it.
module ms_operand_loader (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       flush,
   output logic [7:0] x,
   output logic [7:0] y,
   output logic [7:0] z,
   input  logic [7:0] ms_res,
   input  logic [3:0] ms_st,
   output logic [7:0] out_res,
   output logic [3:0] out_st,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] op_count,
   output logic [3:0] sticky_st
);

   typedef enum logic [2:0] {
      S_X     = 3'd0,
      S_Y     = 3'd1,
      S_Z     = 3'd2,
      S_ISSUE = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t state, state_n;
   logic   accept;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= S_X;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         S_X: begin
            in_ready = 1'b1;
            if (accept) state_n = S_Y;
         end
         S_Y: begin
            in_ready = 1'b1;
            if (accept) state_n = S_Z;
         end
         S_Z: begin
            in_ready = 1'b1;
            if (accept) state_n = S_ISSUE;
         end
         S_ISSUE: state_n = S_HOLD;
         S_HOLD:  if (out_ready) state_n = S_X;
         default: state_n = S_X;
      endcase
      // flush overrides everything except reset, including a pending handshake
      if (flush) state_n = S_X;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= 8'h00;
         y         <= 8'h00;
         z         <= 8'h00;
         out_res   <= 8'h00;
         out_st    <= 4'h0;
         out_valid <= 1'b0;
         op_count  <= 8'h00;
         sticky_st <= 4'h0;
      end else if (flush) begin
         x         <= 8'h00;
         y         <= 8'h00;
         z         <= 8'h00;
         out_valid <= 1'b0;
         sticky_st <= 4'h0;
      end else begin
         case (state)
            S_X: if (accept) x <= in_data;
            S_Y: if (accept) y <= in_data;
            S_Z: if (accept) z <= in_data;
            S_ISSUE: begin
               out_res   <= ms_res;
               out_st    <= ms_st;
               sticky_st <= sticky_st | ms_st;
               out_valid <= 1'b1;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  op_count  <= op_count + 8'h01;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ms_operand_loader.sv
// tb/tb_ms_operand_loader.sv - directed scoreboard bench for ms_operand_loader.
module tb_ms_operand_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [7:0] x, y, z;
   logic [7:0] ms_res;
   logic [3:0] ms_st;
   logic [7:0] out_res;
   logic [3:0] out_st;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] op_count;
   logic [3:0] sticky_st;

   logic [3:0]  st_cfg;
   logic [11:0] sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   // multiply-subtract unit model: res = x*y - z, status chosen per operation
   assign ms_res = 8'(x * y - z);
   assign ms_st  = st_cfg;

   ms_operand_loader dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .x(x), .y(y), .z(z),
      .ms_res(ms_res), .ms_st(ms_st), .out_res(out_res), .out_st(out_st),
      .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count),
      .sticky_st(sticky_st)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int cnt;
      cnt = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && cnt < 50) begin
         step();
         cnt++;
      end
      if (cnt >= 50) chk("send_timeout", 32'd1, 32'd0);
      step();
      in_valid = 1'b0;
   endtask

   task automatic load_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [3:0] st);
      logic [7:0] r;
      st_cfg = st;
      r = 8'(a * b - c);
      sb_q.push_back({r, st});
      send(a);
      send(b);
      send(c);
   endtask

   task automatic wait_valid();
      int cnt;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 50) begin
         step();
         cnt++;
      end
      if (cnt >= 50) chk("valid_timeout", 32'd1, 32'd0);
   endtask

   task automatic take_result(input string tag);
      logic [11:0] e;
      wait_valid();
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_res"}, 32'(out_res), 32'(e[11:4]));
         chk({tag, "_st"},  32'(out_st),  32'(e[3:0]));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] hold_res;
      logic [3:0] hold_st;
      logic [7:0] ra, rb, rc;
      logic [11:0] dropped;

      rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0;
      out_ready = 1'b0; st_cfg = 4'h0;
      step(); step();
      rst = 1'b0;

      // reset state
      chk("rst_x", 32'(x), 32'h0);
      chk("rst_y", 32'(y), 32'h0);
      chk("rst_z", 32'(z), 32'h0);
      chk("rst_out_res", 32'(out_res), 32'h0);
      chk("rst_out_st", 32'(out_st), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_op_count", 32'(op_count), 32'h0);
      chk("rst_sticky", 32'(sticky_st), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);

      // basic operation and two-cycle latency
      load_op(8'h01, 8'h01, 8'h02, 4'b0010);
      chk("basic_x", 32'(x), 32'h01);
      chk("basic_y", 32'(y), 32'h01);
      chk("basic_z", 32'(z), 32'h02);
      chk("basic_issue_valid", 32'(out_valid), 32'h0);
      chk("basic_issue_ready", 32'(in_ready), 32'h0);
      step();
      chk("basic_lat_valid", 32'(out_valid), 32'h1);
      take_result("basic");
      chk("basic_count", 32'(op_count), 32'h1);
      chk("basic_in_ready", 32'(in_ready), 32'h1);
      chk("basic_valid_low", 32'(out_valid), 32'h0);

      // backpressure: result held stable while out_ready is low
      load_op(8'h02, 8'h03, 8'h06, 4'b0001);
      wait_valid();
      hold_res = out_res;
      hold_st  = out_st;
      chk("bp_res_value", 32'(hold_res), 32'h00);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         chk("bp_res_stable", 32'({out_res, out_st}), 32'({hold_res, hold_st}));
         chk("bp_xyz_stable", 32'({x, y, z}), 32'({8'h02, 8'h03, 8'h06}));
      end
      chk("bp_count_before", 32'(op_count), 32'h1);
      take_result("bp");
      chk("bp_count_after", 32'(op_count), 32'h2);
      step();
      chk("bp_count_once", 32'(op_count), 32'h2);

      // gapped input: idle cycles between bytes must not advance the loader
      st_cfg = 4'h0;
      sb_q.push_back({8'(8'h03 * 8'h55 - 8'h0C), 4'h0});
      send(8'h03);
      step();
      chk("gap_x", 32'(x), 32'h03);
      chk("gap_hold_ready", 32'(in_ready), 32'h1);
      send(8'h55);
      step();
      chk("gap_y", 32'(y), 32'h55);
      chk("gap_z_untouched", 32'(z), 32'h06);
      send(8'h0C);
      chk("gap_z", 32'(z), 32'h0C);
      take_result("gap");
      chk("gap_count", 32'(op_count), 32'h3);

      // sticky status accumulation and flush
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush0_sticky", 32'(sticky_st), 32'h0);
      load_op(8'h01, 8'h02, 8'h03, 4'b0001);
      take_result("sticky_a");
      load_op(8'h04, 8'h04, 8'h10, 4'b1000);
      take_result("sticky_b");
      chk("sticky_or", 32'(sticky_st), 32'h9);
      chk("sticky_count", 32'(op_count), 32'h5);
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_sticky", 32'(sticky_st), 32'h0);
      chk("flush_xyz", 32'({x, y, z}), 32'h0);
      chk("flush_count", 32'(op_count), 32'h5);
      chk("flush_out_res_hold", 32'({out_res, out_st}), 32'({8'h00, 4'h8}));

      // flush wins over out_ready in hold
      load_op(8'h05, 8'h05, 8'h01, 4'b0100);
      wait_valid();
      dropped = sb_q.pop_front();
      chk("fh_res_captured", 32'(out_res), 32'(dropped[11:4]));
      flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; out_ready = 1'b0;
      chk("fh_valid", 32'(out_valid), 32'h0);
      chk("fh_count", 32'(op_count), 32'h5);
      chk("fh_in_ready", 32'(in_ready), 32'h1);
      chk("fh_out_res_hold", 32'(out_res), 32'(dropped[11:4]));

      // flush in the issue cycle suppresses capture
      load_op(8'h07, 8'h02, 8'h01, 4'b0010);
      dropped = sb_q.pop_front();
      flush = 1'b1; step(); flush = 1'b0;
      chk("fi_valid", 32'(out_valid), 32'h0);
      chk("fi_sticky", 32'(sticky_st), 32'h0);
      chk("fi_out_res_hold", 32'(out_res), 32'h18);
      step(); step();
      chk("fi_valid_later", 32'(out_valid), 32'h0);
      chk("fi_count", 32'(op_count), 32'h5);

      // reset mid-operation after y loaded
      send(8'h09);
      send(8'h0A);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rm_xyz", 32'({x, y, z}), 32'h0);
      chk("rm_out", 32'({out_res, out_st, out_valid}), 32'h0);
      chk("rm_count", 32'(op_count), 32'h0);
      chk("rm_sticky", 32'(sticky_st), 32'h0);
      chk("rm_in_ready", 32'(in_ready), 32'h1);
      load_op(8'h01, 8'h01, 8'h02, 4'b0010);
      step();
      chk("rm_lat_valid", 32'(out_valid), 32'h1);
      take_result("rm");
      chk("rm_count_after", 32'(op_count), 32'h1);

      // 255 more completed operations wrap the counter to zero
      for (int i = 0; i < 255; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 8'($urandom_range(0, 255));
         load_op(ra, rb, rc, 4'($urandom_range(0, 15)));
         take_result("wrap_op");
         if (i == 253) chk("wrap_count_ff", 32'(op_count), 32'hFF);
      end
      chk("wrap_count_00", 32'(op_count), 32'h00);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ms_operand_loader.md
MS_OPERAND_LOADER -- requirements
Module: ms_operand_loader

Interface
REQ-001 The block SHALL use ports: clk  input  1  rising-edge clock; rst  input  1  reset, synchronous, active-high.
REQ-002 in_data  input  8  operand byte from byte stream.
REQ-003 in_valid  input  1  in_data valid.
REQ-004 in_ready  output  1  block can accept a byte this cycle.
REQ-005 flush  input  1  synchronous discard of partial operands and pending result.
REQ-006 x, y, z  output  8 each  registered operands driven to the downstream multiply-subtract unit.
REQ-007 ms_res  input  8  result returned combinationally by the multiply-subtract unit.
REQ-008 ms_st  input  4  status returned combinationally by the multiply-subtract unit.
REQ-009 out_res  output  8  captured result.
REQ-010 out_st  output  4  captured status.
REQ-011 out_valid  output  1  out_res/out_st valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 op_count  output  8  completed-transfer counter.
REQ-014 sticky_st  output  4  OR of all captured status since last clear.

Function
REQ-015 FSM states SHALL be S_X, S_Y, S_Z, S_ISSUE, S_HOLD.
REQ-016 in_ready SHALL be 1 exactly in S_X, S_Y, S_Z; 0 otherwise.
REQ-017 Byte accepted when in_valid && in_ready; S_X loads x -> S_Y, S_Y loads y -> S_Z, S_Z loads z -> S_ISSUE.
REQ-018 No accept: state and operands hold.
REQ-019 x, y, z SHALL change only on their own load, flush, or reset; stable throughout S_ISSUE and S_HOLD.
REQ-020 S_ISSUE lasts exactly one cycle; at its closing edge out_res <= ms_res, out_st <= ms_st, sticky_st <= sticky_st | ms_st, out_valid <= 1, state -> S_HOLD.
REQ-021 Latency: out_valid asserts the cycle after S_ISSUE, i.e. 2 cycles after the z byte is accepted.
REQ-022 S_HOLD: out_valid=1, out_res/out_st held; on out_ready=1, out_valid <= 0, op_count <= op_count+1, state -> S_X.
REQ-023 out_ready while out_valid=0 SHALL have no effect.
REQ-024 op_count SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-025 Minimum period per operation: 5 cycles (3 loads, issue, 1-cycle hold with out_ready=1).
REQ-026 flush=1 (any state): state -> S_X, x/y/z <= 0, out_valid <= 0, sticky_st <= 0, out_res/out_st hold, op_count hold; in_valid that cycle is ignored.
REQ-027 flush coincident with out_ready in S_HOLD: flush wins, op_count not incremented.
REQ-028 flush coincident with S_ISSUE: capture suppressed, sticky_st cleared.
REQ-029 All outputs SHALL be registered except in_ready, decoded from state.

Reset
REQ-030 rst SHALL take priority over flush and all other inputs.
REQ-031 On rst: state S_X; x, y, z, out_res, op_count = 8'h00; out_st, sticky_st = 4'h0; out_valid = 0; in_ready = 1 the cycle after.
REQ-032 rst mid-operation SHALL discard partial operands and any pending result without incrementing op_count.

Verification
REQ-033 Basic: after rst, send bytes 01, 01, 02 on consecutive cycles, model returns res=8'hFF st=4'b0010 -> x=01 y=01 z=02; out_valid 2 cycles after z; out_res=FF out_st=2; with out_ready=1, op_count=1, in_ready=1 next cycle.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles with result 8'h00 st=4'b0001 -> out_valid stays 1, in_ready stays 0, outputs stable; then out_ready=1 -> op_count increments once.
REQ-035 Gapped input: in_valid toggles 1/0 across bytes 03, 55, 0C -> only valid cycles load; x=03 y=55 z=0C; state never skips.
REQ-036 Sticky: two ops with st=4'b0001 then 4'b1000 -> sticky_st=4'b1001; flush -> sticky_st=0, x=y=z=0, op_count unchanged.
REQ-037 Flush during S_HOLD with out_ready=1 same cycle -> out_valid=0 next cycle, op_count unchanged; 256 completed ops from reset -> op_count=8'h00.
REQ-038 rst asserted after y loaded -> next cycle state S_X, all outputs reset values, subsequent 3-byte load behaves as REQ-033.
